// File: rtl/Common.sv
// Common: shared core-side types.
// mem_inst_type_t encodes a data-port request: bit3 = unsigned load,
// bit2 = store, bits[1:0] = size (byte/half/word/none). Size 2'b11 is a NOP
// regardless of the upper bits.
package Common;

  typedef logic [3:0] mem_inst_type_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_NONE = 2'b11
  } mem_size_t;

  localparam mem_inst_type_t MEM_LB  = 4'b0000;
  localparam mem_inst_type_t MEM_LH  = 4'b0001;
  localparam mem_inst_type_t MEM_LW  = 4'b0010;
  localparam mem_inst_type_t MEM_NOP = 4'b0011;
  localparam mem_inst_type_t MEM_SB  = 4'b0100;
  localparam mem_inst_type_t MEM_SH  = 4'b0101;
  localparam mem_inst_type_t MEM_SW  = 4'b0110;
  localparam mem_inst_type_t MEM_LBU = 4'b1000;
  localparam mem_inst_type_t MEM_LHU = 4'b1001;

  function automatic logic is_store(input mem_inst_type_t t);
    return t[2];
  endfunction

  function automatic mem_size_t mem_size(input mem_inst_type_t t);
    return mem_size_t'(t[1:0]);
  endfunction

  function automatic logic is_unsigned(input mem_inst_type_t t);
    return t[3];
  endfunction

  function automatic logic is_nop(input mem_inst_type_t t);
    return t[1:0] == 2'b11;
  endfunction

endpackage

// File: rtl/riscV_unrn_pkg.sv
// riscV_unrn_pkg: SoC-level address map and console register layout.
// CON_DATA_ADDR / CON_STATUS_ADDR are the default console register addresses;
// CON_ST_* give the bit positions inside the console status word.
package riscV_unrn_pkg;

  localparam logic [31:0] CON_DATA_ADDR   = 32'h1000_0000;
  localparam logic [31:0] CON_STATUS_ADDR = 32'h1000_0004;

  localparam int CON_ST_FULL      = 0;
  localparam int CON_ST_COUNT_LSB = 1;
  localparam int CON_ST_COUNT_W   = 4;
  localparam int CON_ST_OVF       = 8;

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: small byte FIFO feeding the console sink.
// Ports:
//   clk, rst_n      clock, async active-low reset (clears storage too)
//   push_i, data_i  push request and byte
//   ready_i         sink ready; a pop happens when valid_o && ready_i
//   data_o, valid_o head byte and non-empty flag (registered, no path from ready_i)
//   full_o, count_o occupancy
//   drop_o          push rejected this cycle (full with no simultaneous pop)
module byte_fifo #(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [7:0]    data_i,
  input  logic          ready_i,
  output logic [7:0]    data_o,
  output logic          valid_o,
  output logic          full_o,
  output logic [CW-1:0] count_o,
  output logic          drop_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pop;
  logic          push_ok;

  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  // A push into a full FIFO is still accepted when the head leaves in the
  // same cycle; the freed slot is the one being written.
  assign pop     = valid_o && ready_i;
  assign push_ok = push_i && (!full_o || pop);
  assign drop_o  = push_i && full_o && !pop;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (pop)     rd_d = rd_q + PW'(1);
    if (push_ok) wr_d = wr_q + PW'(1);
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      if (push_ok) mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: data-port responder for the single-cycle core.
// Serves a byte-addressable RAM (combinational loads with sign/zero extension,
// byte-enabled stores) and a console TX FIFO with a status register.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   instType_i      request type (Common::mem_inst_type_t)
//   dataAddress_i   byte address
//   writeData_i     right-aligned store data
//   readData_o      extended load result (combinational)
//   access_fault_o  non-NOP access outside every mapped region
//   tx_data_o       console FIFO head byte
//   tx_valid_o      console FIFO non-empty
//   tx_ready_i      byte sink ready
module data_mem_responder
  import Common::*;
  import riscV_unrn_pkg::*;
#(
  parameter logic [31:0] RAM_BASE   = 32'h8000_0000,
  parameter int          RAM_WORDS  = 4096,
  parameter logic [31:0] CON_BASE   = CON_DATA_ADDR,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  mem_inst_type_t instType_i,
  input  logic [31:0]    dataAddress_i,
  input  logic [31:0]    writeData_i,
  output logic [31:0]    readData_o,
  output logic           access_fault_o,
  output logic [7:0]     tx_data_o,
  output logic           tx_valid_o,
  input  logic           tx_ready_i
);

  localparam int          AW       = $clog2(RAM_WORDS);
  localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] CON_STAT = CON_BASE + 32'd4;

  logic [31:0]   ram_q [RAM_WORDS];

  logic          req_nop;
  logic          req_st;
  mem_size_t     req_sz;
  logic [29:0]   word_off;
  logic          ram_hit;
  logic          dat_hit;
  logic          sts_hit;
  logic [AW-1:0] ram_idx;
  logic [31:0]   ram_word;
  logic [3:0]    be;
  logic [31:0]   wrep;
  logic          ram_we;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   status;

  logic          fifo_push;
  logic          fifo_full;
  logic          fifo_drop;
  logic [CW-1:0] fifo_count;
  logic          ovf_q, ovf_d;

  // Decode on word addresses; the subtraction wraps so anything below
  // RAM_BASE lands far above RAM_WORDS and misses.
  assign req_nop  = is_nop(instType_i);
  assign req_st   = is_store(instType_i) && !req_nop;
  assign req_sz   = mem_size(instType_i);
  assign word_off = dataAddress_i[31:2] - RAM_BASE[31:2];
  assign ram_hit  = (word_off < 30'(RAM_WORDS));
  assign dat_hit  = (dataAddress_i[31:2] == CON_BASE[31:2]);
  assign sts_hit  = (dataAddress_i[31:2] == CON_STAT[31:2]);
  assign ram_idx  = word_off[AW-1:0];
  assign ram_word = ram_q[ram_idx];

  assign access_fault_o = !req_nop && !(ram_hit || dat_hit || sts_hit);

  always_comb begin
    be   = 4'b0000;
    wrep = writeData_i;
    case (req_sz)
      SZ_BYTE: begin
        be   = 4'b0001 << dataAddress_i[1:0];
        wrep = {4{writeData_i[7:0]}};
      end
      SZ_HALF: begin
        be   = dataAddress_i[1] ? 4'b1100 : 4'b0011;
        wrep = {2{writeData_i[15:0]}};
      end
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign ram_we = req_st && ram_hit;

  // RAM contents survive reset; only the write itself is gated by rst_n.
  always_ff @(posedge clk) begin
    if (rst_n && ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) ram_q[ram_idx][8*b +: 8] <= wrep[8*b +: 8];
      end
    end
  end

  always_comb begin
    case (dataAddress_i[1:0])
      2'd0:    ld_byte = ram_word[7:0];
      2'd1:    ld_byte = ram_word[15:8];
      2'd2:    ld_byte = ram_word[23:16];
      default: ld_byte = ram_word[31:24];
    endcase
    ld_half = dataAddress_i[1] ? ram_word[31:16] : ram_word[15:0];
  end

  always_comb begin
    status                                     = '0;
    status[CON_ST_FULL]                        = fifo_full;
    status[CON_ST_COUNT_LSB +: CON_ST_COUNT_W] = CON_ST_COUNT_W'(fifo_count);
    status[CON_ST_OVF]                         = ovf_q;
  end

  always_comb begin
    readData_o = '0;
    if (!req_nop && !req_st) begin
      if (ram_hit) begin
        case (req_sz)
          SZ_BYTE: readData_o = is_unsigned(instType_i) ? {24'h0, ld_byte}
                                                       : {{24{ld_byte[7]}}, ld_byte};
          SZ_HALF: readData_o = is_unsigned(instType_i) ? {16'h0, ld_half}
                                                       : {{16{ld_half[15]}}, ld_half};
          SZ_WORD: readData_o = ram_word;
          default: readData_o = '0;
        endcase
      end else if (sts_hit) begin
        readData_o = status;
      end
    end
  end

  assign fifo_push = req_st && dat_hit;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .data_i  (writeData_i[7:0]),
    .ready_i (tx_ready_i),
    .data_o  (tx_data_o),
    .valid_o (tx_valid_o),
    .full_o  (fifo_full),
    .count_o (fifo_count),
    .drop_o  (fifo_drop)
  );

  always_comb begin
    ovf_d = ovf_q;
    if (fifo_drop)          ovf_d = 1'b1;
    if (req_st && sts_hit)  ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

endmodule
